// File: rtl/weigh_pkg.sv
// Shared widths, FSM encoding and arithmetic helper for the weigh filter datapath.
package weigh_pkg;

  localparam int CH_W  = 8;
  localparam int SUM_W = 10;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/ma_window.sv
// Power-of-two moving-average window: circular buffer plus exact running sum.
// One-cycle latency from sample_vld to avg_vld; accepts a sample every cycle.
module ma_window
  import weigh_pkg::*;
#(
  parameter int LOG2_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_vld,
  input  logic [SUM_W-1:0] sample_dat,
  output logic             avg_vld,
  output logic [SUM_W-1:0] avg,
  output logic             full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int RW    = SUM_W + LOG2_DEPTH;

  logic [SUM_W-1:0]      win_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr;
  logic [RW-1:0]         run_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) win_mem[i] <= '0;
      wptr    <= '0;
      run_sum <= '0;
      full    <= 1'b0;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= sample_vld;
      if (sample_vld) begin
        // Slot being overwritten leaves the sum as the new sample enters it.
        run_sum       <= run_sum - RW'(win_mem[wptr]) + RW'(sample_dat);
        win_mem[wptr] <= sample_dat;
        wptr          <= wptr + 1'b1;
        if (&wptr) full <= 1'b1;
      end
    end
  end

  assign avg = run_sum[RW-1:LOG2_DEPTH];

endmodule

// File: rtl/weigh_filter.sv
// Sums three load-cell channels, averages, applies tare and settles detection.
// sample_en -> weight_valid in 3 cycles; accepts a strobe every cycle, no backpressure.
module weigh_filter
  import weigh_pkg::*;
#(
  parameter int LOG2_DEPTH = 3,
  parameter int STABLE_TOL = 2,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [CH_W-1:0]  data_ch1,
  input  logic [CH_W-1:0]  data_ch2,
  input  logic [CH_W-1:0]  data_ch3,
  input  logic             tare_req,
  output logic [SUM_W-1:0] weight,
  output logic             weight_valid,
  output logic             primed,
  output logic             stable
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  logic [SUM_W-1:0] chsum;
  logic             chsum_vld;
  logic             avg_vld;
  logic [SUM_W-1:0] avg;
  logic             win_full;
  logic             upd;
  logic [SUM_W-1:0] prev_avg;
  logic [SUM_W-1:0] offset;
  logic [SUM_W-1:0] delta;
  logic [CNT_W-1:0] steady_cnt;
  logic             tare_pend;
  logic             tare_now;
  state_t           state, state_nxt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      chsum     <= '0;
      chsum_vld <= 1'b0;
    end else begin
      chsum_vld <= sample_en;
      if (sample_en) chsum <= SUM_W'(data_ch1) + SUM_W'(data_ch2) + SUM_W'(data_ch3);
    end
  end

  ma_window #(.LOG2_DEPTH(LOG2_DEPTH)) u_window (
    .clk        (clk_in),
    .rst_n      (rst_n),
    .sample_vld (chsum_vld),
    .sample_dat (chsum),
    .avg_vld    (avg_vld),
    .avg        (avg),
    .full       (win_full)
  );

  // Every update after the window first fills is a primed update.
  assign upd = avg_vld & win_full;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (upd) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = FILL;
    endcase
  end

  assign primed   = (state == RUN);
  // The priming update has no history, so it compares against itself.
  assign delta    = abs_diff(avg, (state == FILL) ? avg : prev_avg);
  assign tare_now = tare_pend | tare_req;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      weight       <= '0;
      weight_valid <= 1'b0;
      prev_avg     <= '0;
      offset       <= '0;
      steady_cnt   <= '0;
      tare_pend    <= 1'b0;
    end else begin
      weight_valid <= upd;
      if (upd) begin
        prev_avg <= avg;
        if (delta <= SUM_W'(STABLE_TOL)) begin
          if (steady_cnt != CNT_W'(STABLE_CNT)) steady_cnt <= steady_cnt + 1'b1;
        end else begin
          steady_cnt <= '0;
        end
        if (tare_now) begin
          offset    <= avg;
          weight    <= '0;
          tare_pend <= 1'b0;
        end else begin
          weight <= (avg >= offset) ? (avg - offset) : '0;
        end
      end else if (tare_req) begin
        tare_pend <= 1'b1;
      end
    end
  end

  assign stable = (steady_cnt == CNT_W'(STABLE_CNT));

endmodule

// File: tb/tb_weigh_filter.sv
// Scoreboard bench for weigh_filter: a reference model queues expected updates at each strobe.
module tb_weigh_filter;

  localparam int LOG2 = 3;
  localparam int DEPTH = 1 << LOG2;
  localparam int TOL = 2;
  localparam int SCNT = 4;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       sample_en;
  logic [7:0] data_ch1, data_ch2, data_ch3;
  logic       tare_req;
  logic [9:0] weight;
  logic       weight_valid, primed, stable;

  weigh_filter #(.LOG2_DEPTH(LOG2), .STABLE_TOL(TOL), .STABLE_CNT(SCNT)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .data_ch1     (data_ch1),
    .data_ch2     (data_ch2),
    .data_ch3     (data_ch3),
    .tare_req     (tare_req),
    .weight       (weight),
    .weight_valid (weight_valid),
    .primed       (primed),
    .stable       (stable)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int w;
    int st;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  int m_win[DEPTH];
  int m_sum, m_wp, m_n, m_pend, m_off, m_prev, m_cnt;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_win[i] = 0;
    m_sum = 0; m_wp = 0; m_n = 0; m_pend = 0; m_off = 0; m_prev = 0; m_cnt = 0;
  endtask

  task automatic model_push(input int s);
    int   avg, d;
    exp_t e;
    m_sum = m_sum - m_win[m_wp] + s;
    m_win[m_wp] = s;
    m_wp = (m_wp + 1) % DEPTH;
    m_n++;
    if (m_n >= DEPTH) begin
      avg = m_sum / DEPTH;
      d = (m_n == DEPTH) ? 0 : ((avg > m_prev) ? avg - m_prev : m_prev - avg);
      m_prev = avg;
      if (d <= TOL) m_cnt = (m_cnt < SCNT) ? m_cnt + 1 : SCNT;
      else m_cnt = 0;
      if (m_pend != 0) begin
        m_off = avg;
        e.w = 0;
        m_pend = 0;
      end else begin
        e.w = (avg >= m_off) ? avg - m_off : 0;
      end
      e.st = (m_cnt == SCNT) ? 1 : 0;
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic drive(input int c1, input int c2, input int c3);
    @(negedge clk_in);
    data_ch1 = 8'(c1);
    data_ch2 = 8'(c2);
    data_ch3 = 8'(c3);
    sample_en = 1'b1;
    model_push(c1 + c2 + c3);
  endtask

  task automatic idle(input int n);
    @(negedge clk_in);
    sample_en = 1'b0;
    repeat (n - 1) @(negedge clk_in);
  endtask

  task automatic spaced(input int c1, input int c2, input int c3);
    drive(c1, c2, c3);
    idle(15);
  endtask

  task automatic tare();
    @(negedge clk_in);
    tare_req = 1'b1;
    m_pend = 1;
    @(negedge clk_in);
    tare_req = 1'b0;
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    sample_en = 1'b0;
    tare_req = 1'b0;
    #1;
    check({tag, "_weight"}, int'(weight), 0);
    check({tag, "_valid"}, int'(weight_valid), 0);
    check({tag, "_primed"}, int'(primed), 0);
    check({tag, "_stable"}, int'(stable), 0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  always @(negedge clk_in) begin
    if (rst_n === 1'b1 && weight_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", cyc, e.cyc);
        check("weight", int'(weight), e.w);
        check("stable", int'(stable), e.st);
        check("primed_at_valid", int'(primed), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    sample_en = 1'b0;
    tare_req = 1'b0;
    data_ch1 = '0; data_ch2 = '0; data_ch3 = '0;
    #23;
    check("rst_weight", int'(weight), 0);
    check("rst_valid", int'(weight_valid), 0);
    check("rst_primed", int'(primed), 0);
    check("rst_stable", int'(stable), 0);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Fill with 60: only the eighth strobe produces an update
    for (int i = 0; i < DEPTH; i++) begin
      spaced(10, 20, 30);
      if (i == DEPTH - 2) check("primed_before_full", int'(primed), 0);
    end
    check("primed_after_full", int'(primed), 1);
    check("fill_weight", int'(weight), 60);

    // Tare, then step the sum to 70
    tare();
    spaced(10, 20, 30);
    check("tare_weight", int'(weight), 0);
    for (int i = 0; i < DEPTH; i++) spaced(20, 20, 30);
    check("step_final", int'(weight), 10);

    // Clamp: re-tare at 60 then drop to 50
    for (int i = 0; i < DEPTH; i++) spaced(10, 20, 30);
    tare();
    spaced(10, 20, 30);
    for (int i = 0; i < 10; i++) spaced(10, 20, 20);
    check("clamp_weight", int'(weight), 0);

    // Settle at 60, then jump to 90
    for (int i = 0; i < 12; i++) spaced(10, 20, 30);
    check("settled", int'(stable), 1);
    spaced(30, 30, 30);
    check("stable_drop", int'(stable), 0);

    // Full-scale input with no tare
    reset_dut("rst_full");
    for (int i = 0; i < DEPTH; i++) spaced(255, 255, 255);
    check("full_scale", int'(weight), 765);

    // Back-to-back strobes
    for (int i = 0; i < DEPTH; i++) drive(i * 30, 7, i);
    idle(8);

    // Reset with a sample in flight
    drive(1, 2, 3);
    idle(1);
    reset_dut("rst_inflight");
    repeat (6) @(negedge clk_in);

    // Reset mid-fill discards a pending tare
    for (int i = 0; i < 5; i++) spaced(10, 20, 30);
    tare();
    reset_dut("rst_midfill");
    for (int i = 0; i < DEPTH; i++) spaced(10, 20, 30);
    check("refill_weight", int'(weight), 60);
    check("refill_primed", int'(primed), 1);

    repeat (10) @(negedge clk_in);
    check("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/weigh_filter.md
Name: weigh_filter

Overview:
- Sits directly downstream of the three-channel ADC sampler and consumes its registered 8-bit channel values data_ch1..data_ch3.
- On each sample strobe it sums the three load-cell channels and runs the result through a power-of-two moving-average window.
- It applies a tare (zero) offset and flags when the reading has settled.
- The net weight feeds the display/BCD stage.

Parameters:
- LOG2_DEPTH, 3: log2 of the moving-average window depth (DEPTH = 2^LOG2_DEPTH entries, 1..5 supported).
- STABLE_TOL, 2: maximum |avg change| per update still counted as steady.
- STABLE_CNT, 4: consecutive steady updates required to assert stable.

Ports:
- clk_in, input, 1: system clock, the same clock that drives the ADC sampler.
- rst_n, input, 1: asynchronous active-low reset.
- sample_en, input, 1: one-cycle strobe; data_ch1..3 are valid and complete for this frame.
- data_ch1, input, 8: channel 1 sample.
- data_ch2, input, 8: channel 2 sample.
- data_ch3, input, 8: channel 3 sample.
- tare_req, input, 1: one-cycle request to zero the scale at the current reading.
- weight, output, 10: net filtered weight, avg minus tare offset, clamped at 0.
- weight_valid, output, 1: one-cycle pulse when weight updates.
- primed, output, 1: the window has been filled with real samples.
- stable, output, 1: the reading has settled.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n is asynchronous, active-low.
- Reset values: weight=0, weight_valid=0, primed=0, stable=0. Window buffer, running sum, tare offset, steady counter and tare-pending flag all 0. FSM in FILL.
- Stage 1 (cycle after sample_en): chsum = data_ch1+data_ch2+data_ch3, zero-extended to 10 bits (max 765, no overflow). chsum_vld registered.
- Stage 2: the circular buffer is indexed by a LOG2_DEPTH-bit write pointer, which wraps DEPTH-1 -> 0.
  - run_sum <= run_sum - buf[wptr] + chsum.
  - buf[wptr] <= chsum.
  - wptr increments.
  - run_sum width = 10+LOG2_DEPTH bits; it is exact and never overflows.
- Stage 3: avg = run_sum >> LOG2_DEPTH, truncating.
  - weight <= (avg >= offset) ? avg - offset : 0.
  - weight_valid pulses when primed (or when this update primes the window).
- Latency: sample_en at cycle N -> weight/weight_valid at cycle N+3. The pipeline accepts sample_en every cycle; no back-pressure.
- FSM states:
  - FILL: counts stage-2 writes. On the write that fills slot DEPTH-1 -> RUN, and primed=1 from that same update's stage 3. weight_valid is suppressed in FILL.
  - RUN: steady operation. It leaves RUN only on reset.
- Tare:
  - tare_req on any cycle sets tare_pend.
  - At the next stage-3 update with primed: offset <= avg, weight <= 0 for that update, tare_pend cleared.
  - tare_req during FILL stays pending until the first primed update.
  - tare_req coincident with a stage-3 update applies to that update.
  - Repeated requests while pending collapse to one.
- Stable:
  - Evaluated at each primed stage-3 update. d = |avg - prev_avg|; prev_avg is updated every update.
  - If d <= STABLE_TOL, the counter increments, saturating at STABLE_CNT. Otherwise the counter goes to 0 and stable drops in the same cycle weight updates.
  - stable = (counter == STABLE_CNT).
  - A tare does not clear stable.
  - The first primed update compares against its own value, so d=0.
- Reset mid-operation: all state clears immediately, including in-flight pipeline stages and pending tare. Refill is required before the next weight_valid.

Decomposition:
- Shared package weigh_pkg:
  - width constants CH_W=8 and SUM_W=10.
  - FSM state encoding FILL/RUN.
  - the helper function for unsigned absolute difference.
- One sub-module: ma_window (circular buffer + running sum + pointer/fill count, parameterised by LOG2_DEPTH, outputs avg and full).
- Tare, stable and output registers stay in weigh_filter.

Test Plan:
- Fill: channels 10/20/30 held, 8 sample_en strobes every 16 cycles -> no weight_valid for the first 7. The 8th gives weight=60, primed=1, 3 cycles after its strobe.
- Tare and step: tare_req after priming -> next update weight=0. Then chsum=70 -> weights 1,2,3,5,6,7,8,10, one per strobe (run_sum/8 - 60).
- Clamp: after tare at 60, chsum=50 held -> weight stays 0, never wraps to a large value.
- Stable: constant 60 after priming -> stable=1 on the 4th primed update. A chsum jump to 90 (avg step 3 > TOL) -> stable=0 the same cycle.
- Boundary: all channels 255 for 8 strobes -> weight=765. Back-to-back sample_en every cycle -> 8 consecutive weight_valid once primed.
- Reset mid-fill: rst_n low after 5 strobes -> all outputs 0 asynchronously. Refill with 8 strobes is required, and a tare_req issued before the reset is discarded.
